// File: rtl/aplpll_lock_ctrl.sv
// PLL reset/lock sequencer on the reference clock: holds the PLL in reset, waits for lock with
// bounded retries, qualifies lock as stable and then releases the downstream system reset.
module aplpll_lock_ctrl #(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic       lol_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [3:0]       retry_r;
  logic [3:0]       retry_nxt_s;
  logic             lol_r;
  logic             lol_nxt_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             lk_s;
  logic             pll_rst_r;
  logic             sys_rst_n_r;
  logic             ready_r;
  logic             fail_r;
  logic             pll_rst_nxt_s;
  logic             sys_rst_n_nxt_s;
  logic             ready_nxt_s;
  logic             fail_nxt_s;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pll_locked_i;
      sync2_r <= sync1_r;
    end
  end

  assign lk_s = sync2_r;

  // Next-state, counter, retry and loss-of-lock decode; restart overrides everything
  always_comb begin
    next_state_s = ST_RESET;
    retry_nxt_s  = retry_r;
    lol_nxt_s    = lol_r;
    if (restart_i) begin
      next_state_s = ST_RESET;
      retry_nxt_s  = 4'd0;
      lol_nxt_s    = 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (cnt_r == HOLD_LAST) begin
            next_state_s = ST_WAIT_LOCK;
          end else begin
            next_state_s = ST_RESET;
          end
        end
        ST_WAIT_LOCK: begin
          // lock seen on the timeout cycle still wins
          if (lk_s) begin
            next_state_s = ST_STABLE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            if (retry_r < RETRY_MAX) begin
              retry_nxt_s  = retry_r + 4'd1;
              next_state_s = ST_RESET;
            end else begin
              next_state_s = ST_FAIL;
            end
          end else begin
            next_state_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!lk_s) begin
            next_state_s = ST_WAIT_LOCK;
          end else if (cnt_r == STABLE_LAST) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            lol_nxt_s    = 1'b1;
            retry_nxt_s  = 4'd0;
            next_state_s = ST_RESET;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_FAIL: begin
          next_state_s = ST_FAIL;
        end
        default: begin
          next_state_s = ST_RESET;
        end
      endcase
    end

    // Counter restarts on every state change and saturates instead of wrapping
    if (restart_i || (next_state_s != state_r)) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end

    pll_rst_nxt_s   = (next_state_s == ST_RESET) || (next_state_s == ST_FAIL);
    sys_rst_n_nxt_s = (next_state_s == ST_RUN);
    ready_nxt_s     = (next_state_s == ST_RUN);
    fail_nxt_s      = (next_state_s == ST_FAIL);
  end

  // State, counter and status registers
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
      cnt_r   <= '0;
      retry_r <= 4'd0;
      lol_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
      retry_r <= retry_nxt_s;
      lol_r   <= lol_nxt_s;
    end
  end

  // Output registers, loaded from the next-state decode so they track state_o
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_r   <= 1'b1;
      sys_rst_n_r <= 1'b0;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      pll_rst_r   <= pll_rst_nxt_s;
      sys_rst_n_r <= sys_rst_n_nxt_s;
      ready_r     <= ready_nxt_s;
      fail_r      <= fail_nxt_s;
    end
  end

  assign pll_rst_o   = pll_rst_r;
  assign sys_rst_n_o = sys_rst_n_r;
  assign ready_o     = ready_r;
  assign fail_o      = fail_r;
  assign lol_o       = lol_r;
  assign retry_cnt_o = retry_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_aplpll_lock_ctrl.sv
// Table-driven bench for aplpll_lock_ctrl: vectors hold input levels, cycle counts and the
// expected registered outputs; hand-written sequences cover async reset and release timing.
module tb_aplpll_lock_ctrl;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STB  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       restart_i;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       ready_o;
  logic       fail_o;
  logic       lol_o;
  logic [3:0] retry_cnt_o;
  logic [2:0] state_o;

  typedef struct {
    logic        lk;
    logic        rs;
    int          n;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  aplpll_lock_ctrl #(
    .RST_HOLD    (4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .MAX_RETRY   (2),
    .CNT_W       (17)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked_i(pll_locked_i),
    .restart_i   (restart_i),
    .pll_rst_o   (pll_rst_o),
    .sys_rst_n_o (sys_rst_n_o),
    .ready_o     (ready_o),
    .fail_o      (fail_o),
    .lol_o       (lol_o),
    .retry_cnt_o (retry_cnt_o),
    .state_o     (state_o)
  );

  always #5 refclk = ~refclk;

  // expected packing: {state, pll_rst, sys_rst_n, ready, fail, lol, retry}
  function automatic logic [11:0] pack_exp(input logic [2:0] st, input logic lo, input logic [3:0] rc);
    logic pr;
    logic sr;
    logic fl;
    pr = (st == S_RST) || (st == S_FAIL);
    sr = (st == S_RUN);
    fl = (st == S_FAIL);
    return {st, pr, sr, sr, fl, lo, rc};
  endfunction

  function automatic logic [11:0] act();
    return {state_o, pll_rst_o, sys_rst_n_o, ready_o, fail_o, lol_o, retry_cnt_o};
  endfunction

  task automatic add(input logic lk, input logic rs, input int n, input logic [2:0] st,
                     input logic lo, input logic [3:0] rc);
    vec_t v;
    v.lk  = lk;
    v.rs  = rs;
    v.n   = n;
    v.exp = pack_exp(st, lo, rc);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got st=%0d prst=%b srstn=%b rdy=%b fail=%b lol=%b retry=%0d exp st=%0d prst=%b srstn=%b rdy=%b fail=%b lol=%b retry=%0d",
               name, got[11:9], got[8], got[7], got[6], got[5], got[4], got[3:0],
               exp[11:9], exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int n_cyc;
    int n_prst;

    rst_n        = 1'b0;
    pll_locked_i = 1'b0;
    restart_i    = 1'b0;

    // nominal bring-up, PLL locks 10 cycles after pll_rst falls
    add(1'b0, 1'b0, 3,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_WAIT, 1'b0, 4'd0);
    add(1'b0, 1'b0, 9,    S_WAIT, 1'b0, 4'd0);
    add(1'b1, 1'b0, 2,    S_WAIT, 1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 7,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_RUN,  1'b0, 4'd0);
    add(1'b1, 1'b0, 20,   S_RUN,  1'b0, 4'd0);
    // loss of lock for 3 cycles in RUN
    add(1'b0, 1'b0, 2,    S_RUN,  1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_RST,  1'b1, 4'd0);
    add(1'b1, 1'b0, 3,    S_RST,  1'b1, 4'd0);
    add(1'b1, 1'b0, 1,    S_WAIT, 1'b1, 4'd0);
    add(1'b1, 1'b0, 1,    S_STB,  1'b1, 4'd0);
    add(1'b1, 1'b0, 7,    S_STB,  1'b1, 4'd0);
    add(1'b1, 1'b0, 1,    S_RUN,  1'b1, 4'd0);
    // restart held 5 cycles in RUN clears lol, then 4 more RESET cycles
    add(1'b1, 1'b1, 1,    S_RST,  1'b0, 4'd0);
    add(1'b1, 1'b1, 4,    S_RST,  1'b0, 4'd0);
    add(1'b1, 1'b0, 3,    S_RST,  1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_WAIT, 1'b0, 4'd0);
    // one-cycle glitch seen at STABLE cnt=5
    add(1'b1, 1'b0, 1,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 3,    S_STB,  1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_WAIT, 1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 7,    S_STB,  1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_RUN,  1'b0, 4'd0);
    // synced lock arrives exactly on the timeout cycle
    add(1'b0, 1'b1, 1,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 3,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_WAIT, 1'b0, 4'd0);
    add(1'b0, 1'b0, 17,   S_WAIT, 1'b0, 4'd0);
    add(1'b1, 1'b0, 2,    S_WAIT, 1'b0, 4'd0);
    add(1'b1, 1'b0, 1,    S_STB,  1'b0, 4'd0);
    // never locks: three windows then FAIL, restart recovers
    add(1'b0, 1'b1, 1,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 3,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_WAIT, 1'b0, 4'd0);
    add(1'b0, 1'b0, 19,   S_WAIT, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_RST,  1'b0, 4'd1);
    add(1'b0, 1'b0, 3,    S_RST,  1'b0, 4'd1);
    add(1'b0, 1'b0, 1,    S_WAIT, 1'b0, 4'd1);
    add(1'b0, 1'b0, 19,   S_WAIT, 1'b0, 4'd1);
    add(1'b0, 1'b0, 1,    S_RST,  1'b0, 4'd2);
    add(1'b0, 1'b0, 3,    S_RST,  1'b0, 4'd2);
    add(1'b0, 1'b0, 1,    S_WAIT, 1'b0, 4'd2);
    add(1'b0, 1'b0, 19,   S_WAIT, 1'b0, 4'd2);
    add(1'b0, 1'b0, 1,    S_FAIL, 1'b0, 4'd2);
    add(1'b0, 1'b0, 1000, S_FAIL, 1'b0, 4'd2);
    add(1'b0, 1'b1, 1,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 3,    S_RST,  1'b0, 4'd0);
    add(1'b0, 1'b0, 1,    S_WAIT, 1'b0, 4'd0);

    repeat (3) @(negedge refclk);
    check("reset_values", act(), pack_exp(S_RST, 1'b0, 4'd0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pll_locked_i = tbl[i].lk;
      restart_i    = tbl[i].rs;
      repeat (tbl[i].n) @(negedge refclk);
      check($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // async reset in the middle of STABLE
    pll_locked_i = 1'b1;
    repeat (3) @(negedge refclk);
    check("pre_async_stable", act(), pack_exp(S_STB, 1'b0, 4'd0));
    repeat (2) @(negedge refclk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", act(), pack_exp(S_RST, 1'b0, 4'd0));
    @(negedge refclk);
    check("async_reset_held", act(), pack_exp(S_RST, 1'b0, 4'd0));
    rst_n = 1'b1;

    // full sequence after release: 4 RESET + 1 WAIT + 8 STABLE cycles, bounded wait
    n_cyc  = 0;
    n_prst = 0;
    while (!ready_o && n_cyc < 60) begin
      @(negedge refclk);
      n_cyc++;
      if (pll_rst_o) n_prst++;
    end
    check_int("release_cycles_to_run", n_cyc, 13);
    check_int("release_pll_rst_samples", n_prst, 3);
    check("release_run_state", act(), pack_exp(S_RUN, 1'b0, 4'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
